// File: rtl/zxuno_regs_pkg.sv
// ZX-Uno register bus: I/O port map, register numbers, Z80 bus sample type.
// Shared by the register port front end and all downstream register blocks.
package zxuno_regs_pkg;

  localparam logic [15:0] ADDR_PORT_DEF = 16'hFC3B;
  localparam logic [15:0] DATA_PORT_DEF = 16'hFD3B;
  localparam logic [7:0]  ADDR_RST_DEF  = 8'h00;

  localparam logic [7:0] MASTERCONF   = 8'h00;
  localparam logic [7:0] MASTERMAPPER = 8'h01;
  localparam logic [7:0] FLASHSPI     = 8'h02;
  localparam logic [7:0] FLASHCS      = 8'h03;
  localparam logic [7:0] SCANCODE     = 8'h04;
  localparam logic [7:0] KEYBSTAT     = 8'h05;
  localparam logic [7:0] JOYCONF      = 8'h06;
  localparam logic [7:0] KEYMAP       = 8'h07;
  localparam logic [7:0] COREID       = 8'hFF;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_ADDR,
    SEL_DATA
  } port_sel_t;

  typedef struct packed {
    logic [15:0] a;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic        m1_n;
    logic [7:0]  data;
  } bus_t;

  // Reset sample looks like a write in progress, so a write still
  // held low when reset lifts is seen as "already active".
  localparam bus_t BUS_RST = '{
    a:      16'h0000,
    iorq_n: 1'b0,
    rd_n:   1'b1,
    wr_n:   1'b0,
    m1_n:   1'b1,
    data:   8'h00
  };

  function automatic logic io_wr_f(bus_t b);
    return !b.iorq_n && !b.wr_n && b.m1_n;
  endfunction

  function automatic logic io_rd_f(bus_t b);
    return !b.iorq_n && !b.rd_n && b.m1_n;
  endfunction

endpackage

// File: rtl/zxuno_register_port_if.sv
// Z80 I/O bus in, shared register bus out.
// master: CPU/board side driving the Z80 pins; slave: register port.
interface zxuno_register_port_if;
  logic [15:0] a;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic        m1_n;
  logic [7:0]  cpudin;
  logic [7:0]  zxuno_addr;
  logic        zxuno_regrd;
  logic        zxuno_regwr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        oe;
  logic        addr_wr;

  modport master (
    output a, iorq_n, rd_n, wr_n, m1_n, cpudin,
    input  zxuno_addr, zxuno_regrd, zxuno_regwr,
    input  din, dout, oe, addr_wr
  );

  modport slave (
    input  a, iorq_n, rd_n, wr_n, m1_n, cpudin,
    output zxuno_addr, zxuno_regrd, zxuno_regwr,
    output din, dout, oe, addr_wr
  );
endinterface

// File: rtl/zxuno_strobe_edge.sv
// Rising-activity detector: registered level in, one-cycle pulse out.
// Ports: clk, rst_n, level (registered strobe), pulse (first active cycle).
module zxuno_strobe_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  logic hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist <= 1'b1;
    else        hist <= level;
  end

  assign pulse = level & ~hist;

endmodule

// File: rtl/zxuno_register_port.sv
// ZX-Uno register port: FC3Bh/FD3Bh decode, register number latch, strobes.
// Ports: clk, rst_n, bus (slave: Z80 pins in, register bus out).
module zxuno_register_port
  import zxuno_regs_pkg::*;
#(
  parameter logic [15:0] ADDR_PORT = ADDR_PORT_DEF,
  parameter logic [15:0] DATA_PORT = DATA_PORT_DEF,
  parameter logic [7:0]  ADDR_RST  = ADDR_RST_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  zxuno_register_port_if.slave bus
);

  bus_t      bus_q;
  port_sel_t sel;
  logic      io_wr;
  logic      io_rd;
  logic      wr_pulse;
  logic      rd_ok;
  logic [7:0] addr_q;
  logic [7:0] din_q;
  logic       regwr_q;
  logic       regrd_q;
  logic       oe_q;
  logic       addr_wr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_q <= BUS_RST;
    end else begin
      bus_q <= '{
        a:      bus.a,
        iorq_n: bus.iorq_n,
        rd_n:   bus.rd_n,
        wr_n:   bus.wr_n,
        m1_n:   bus.m1_n,
        data:   bus.cpudin
      };
    end
  end

  assign io_wr = io_wr_f(bus_q);
  assign io_rd = io_rd_f(bus_q);
  // a write wins when rd_n and wr_n are both low
  assign rd_ok = io_rd & ~io_wr;

  always_comb begin
    sel = SEL_NONE;
    unique case (1'b1)
      (bus_q.a == ADDR_PORT): sel = SEL_ADDR;
      (bus_q.a == DATA_PORT): sel = SEL_DATA;
      default:                sel = SEL_NONE;
    endcase
  end

  zxuno_strobe_edge u_wr_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (io_wr),
    .pulse (wr_pulse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= ADDR_RST;
      din_q     <= 8'h00;
      regwr_q   <= 1'b0;
      regrd_q   <= 1'b0;
      oe_q      <= 1'b0;
      addr_wr_q <= 1'b0;
    end else begin
      regwr_q   <= wr_pulse && sel == SEL_DATA;
      addr_wr_q <= wr_pulse && sel == SEL_ADDR;
      regrd_q   <= rd_ok && sel == SEL_DATA;
      oe_q      <= rd_ok && sel == SEL_ADDR;
      if (wr_pulse && sel == SEL_DATA) din_q  <= bus_q.data;
      if (wr_pulse && sel == SEL_ADDR) addr_q <= bus_q.data;
    end
  end

  assign bus.zxuno_addr  = addr_q;
  assign bus.zxuno_regrd = regrd_q;
  assign bus.zxuno_regwr = regwr_q;
  assign bus.din         = din_q;
  assign bus.dout        = addr_q;
  assign bus.oe          = oe_q;
  assign bus.addr_wr     = addr_wr_q;

endmodule
